// File: rtl/fmul_pkg.sv
// fmul_pkg: shared types and constants for the float_mult issue scheduler
package fmul_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_SETTLE, S_CAPTURE
   } state_e;
   localparam logic FP16 = 1'b0;
   localparam logic FP32 = 1'b1;
   localparam logic [31:0] FP32_INF = 32'h7f80_0000;
   localparam logic [15:0] FP16_INF = 16'h7c00;
   typedef struct packed {
      logic        typ;
      logic [31:0] a;
      logic [31:0] b;
   } req_t;
endpackage

// File: rtl/fmul_req_fifo.sv
// fmul_req_fifo: DEPTH x 65-bit {type,a,b} synchronous request FIFO
// Ports: push_i/data_i write side, pop_i/data_o read side (data_o shows head),
//        full_o/empty_o derived from a registered occupancy count.
module fmul_req_fifo
   import fmul_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push_i,
   input  req_t data_i,
   input  logic pop_i,
   output req_t data_o,
   output logic full_o,
   output logic empty_o
);
   localparam int AW = $clog2(DEPTH);
   req_t          mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_q];
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_q + AW'(do_push);
         rd_q  <= rd_q + AW'(do_pop);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end
endmodule

// File: rtl/fmul_issue_sched.sv
// fmul_issue_sched: buffers fp16/fp32 multiply requests and issues them one at a time to float_mult
// Ports: req_* valid/ready request channel, mul_* drive/observe float_mult,
//        rsp_* valid/ready response channel {type, data, {error,overflow}}.
module fmul_issue_sched
   import fmul_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int BYPASS_WAIT = 3,
   parameter int SETTLE      = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_type,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        mul_valid,
   input  logic        mul_ready,
   output logic        mul_type,
   output logic [31:0] mul_in1_32,
   output logic [31:0] mul_in2_32,
   output logic [15:0] mul_in1_16,
   output logic [15:0] mul_in2_16,
   input  logic [31:0] mul_out_32,
   input  logic [15:0] mul_out_16,
   input  logic        mul_ovf,
   input  logic        mul_err,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_type,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_flags
);
   localparam int CMAX = (BYPASS_WAIT > SETTLE) ? BYPASS_WAIT : SETTLE;
   localparam int CW   = $clog2(CMAX) + 1;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   req_t          head;
   logic          full, empty, pop, load;
   logic          typ_q;
   logic [31:0]   in1_32_q, in2_32_q;
   logic [15:0]   in1_16_q, in2_16_q;
   logic          rsp_valid_q, rsp_type_q;
   logic [31:0]   rsp_data_q;
   logic [1:0]    rsp_flags_q;
   fmul_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (req_valid && !full),
      .data_i  ('{typ: req_type, a: req_a, b: req_b}),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );
   assign req_ready  = !full;
   assign mul_valid  = state_q == S_ISSUE;
   assign mul_type   = typ_q;
   assign mul_in1_32 = in1_32_q;
   assign mul_in2_32 = in2_32_q;
   assign mul_in1_16 = in1_16_q;
   assign mul_in2_16 = in2_16_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_type   = rsp_type_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_flags  = rsp_flags_q;
   // float_mult gives no completion strobe: a falling then rising mul_ready marks a
   // computed op, while mul_ready staying high for BYPASS_WAIT cycles marks a
   // special-value op whose result was valid right away.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty && mul_ready) begin
               pop     = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_LO;
            cnt_d   = '0;
         end
         S_WAIT_LO: begin
            if (!mul_ready) state_d = S_WAIT_HI;
            else if (cnt_q == CW'(BYPASS_WAIT - 1)) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         S_WAIT_HI: begin
            if (mul_ready) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end
         end
         S_SETTLE: begin
            if (cnt_q == CW'(SETTLE - 1)) state_d = S_CAPTURE;
            else cnt_d = cnt_q + CW'(1);
         end
         S_CAPTURE: begin
            if (!rsp_valid_q || rsp_ready) begin
               load    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   // operands are only reloaded on a pop, so they stay frozen for the whole op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         typ_q    <= FP16;
         in1_32_q <= '0;
         in2_32_q <= '0;
         in1_16_q <= '0;
         in2_16_q <= '0;
      end else if (pop) begin
         typ_q    <= head.typ;
         in1_32_q <= head.typ ? head.a : '0;
         in2_32_q <= head.typ ? head.b : '0;
         in1_16_q <= head.typ ? '0 : head.a[15:0];
         in2_16_q <= head.typ ? '0 : head.b[15:0];
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_type_q  <= 1'b0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
      end else if (load) begin
         rsp_valid_q <= 1'b1;
         rsp_type_q  <= typ_q;
         rsp_data_q  <= typ_q ? mul_out_32 : {16'h0, mul_out_16};
         rsp_flags_q <= {mul_err, mul_ovf};
      end else if (rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end
endmodule
